// File: rtl/io_intr_port_pkg.sv
// io_intr_port_pkg.sv - shared constants and types for the io interrupt port.
// Package name: lib_io. Imported by io_fifo users and by io_intr_port.
package lib_io;

  // io register map
  localparam logic [7:0] IO_DATA   = 8'h00;
  localparam logic [7:0] IO_STATUS = 8'h01;
  localparam logic [7:0] IO_CTRL   = 8'h02;
  localparam logic [7:0] IO_EOI    = 8'h03;

  // Threshold value after reset, and the value a written zero is coerced to
  localparam logic [7:0] THR_MIN = 8'd1;

  // Control register: interrupt threshold level and interrupt enable
  typedef struct packed {
    logic [7:0] thr;
    logic       ien;
  } io_ctrl_t;

  // STATUS read word, laid out exactly as the CPU sees it
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        ovf_intr;  // 1 when overflow can also raise the interrupt
    logic        ovf;
    logic        full;
    logic        empty;
  } io_status_t;

  // Interrupt lifecycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  // CTRL read word: bits[15:8]=thr, bit0=ien
  function automatic logic [31:0] ctrl_to_word(input io_ctrl_t c);
    return {16'h0000, c.thr, 7'h00, c.ien};
  endfunction

  // A threshold of zero would fire permanently; it is stored as one instead
  function automatic logic [7:0] thr_sanitize(input logic [7:0] thr);
    return (thr == 8'h00) ? THR_MIN : thr;
  endfunction

endpackage

// File: rtl/io_intr_port_fifo.sv
// io_intr_port_fifo.sv - byte FIFO (module io_fifo) buffering device input.
// Handles storage, wrap-around pointers, occupancy count and same-cycle
// push/pop. A push while full and a pop while empty are ignored here.
module io_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_STEP   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_STEP   = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify requests against the state seen at the start of the cycle
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next pointers and count; pointers wrap naturally since DEPTH is 2**AW
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_STEP;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_STEP;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_STEP;
      2'b01:   count_d = count_q - CNT_STEP;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count and empty flag guard every read.
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_intr_port.sv
// io_intr_port.sv - CPU io responder and interrupt request source.
// Serves CPU io reads/writes (DATA, STATUS, CTRL, EOI), buffers device bytes
// in io_fifo, tracks overflow, and runs the IDLE/PEND/SERVICE interrupt FSM
// that drives irr.
// Optional feature macro: IO_OVF_INTR_EN - when defined, a sticky overflow
// also raises the interrupt and STATUS bit3 reads 1.
module io_intr_port
  import lib_io::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        dev_valid,
  input  logic [7:0]  dev_data,
  output logic        dev_ready,
  input  logic        intr_ack,
  output logic        irr
);

`ifdef IO_OVF_INTR_EN
  localparam logic OVF_INTR_FEATURE = 1'b1;
`else
  localparam logic OVF_INTR_FEATURE = 1'b0;
`endif

  // FIFO interface
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        push;
  logic        pop;

  // Register state
  io_ctrl_t    ctrl_q;
  logic        ovf_q;
  intr_state_t state_q;
  logic        irr_q;
  logic [31:0] io_rdata_q;

  // Decode and derived signals
  logic        rd_data;
  logic        wr_ctrl;
  logic        wr_eoi;
  logic [31:0] count_ext;
  logic        level_hit;
  logic        intr_trigger;
  io_status_t  status;
  logic [31:0] rdata_d;
  logic        unused_wdata;

  assign rd_data = io_re && (io_addr == IO_DATA);
  assign wr_ctrl = io_we && (io_addr == IO_CTRL);
  assign wr_eoi  = io_we && (io_addr == IO_EOI);

  // Device side: accept whenever there is room; the FIFO ignores an empty pop
  assign dev_ready = ~fifo_full;
  assign push      = dev_valid & dev_ready;
  assign pop       = rd_data;

  io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (dev_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Threshold compare done at a common width so any DEPTH works
  assign count_ext = 32'(fifo_count);
  assign level_hit = (count_ext >= 32'(ctrl_q.thr));

`ifdef IO_OVF_INTR_EN
  assign intr_trigger = ctrl_q.ien & (level_hit | ovf_q);
`else
  assign intr_trigger = ctrl_q.ien & level_hit;
`endif

  // Only bit0 and bits[15:8] of write data are meaningful
  assign unused_wdata = ^{io_wdata[31:16], io_wdata[7:1]};

  // STATUS word assembly; count is zero-extended/truncated to 8 bits
  always_comb begin
    status          = '0;
    status.count    = count_ext[7:0];
    status.ovf_intr = OVF_INTR_FEATURE;
    status.ovf      = ovf_q;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
  end

  // Read mux; all values reflect state before any same-cycle write
  always_comb begin
    rdata_d = '0;
    case (io_addr)
      IO_DATA:   rdata_d = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      IO_STATUS: rdata_d = status;
      IO_CTRL:   rdata_d = ctrl_to_word(ctrl_q);
      default:   rdata_d = '0;
    endcase
  end

  // Read data register: loads only on a read strobe, otherwise holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     io_rdata_q <= '0;
    else if (io_re) io_rdata_q <= rdata_d;
  end

  // Control register: enable and threshold, zero threshold coerced to one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q.ien <= 1'b0;
      ctrl_q.thr <= THR_MIN;
    end else if (wr_ctrl) begin
      ctrl_q.ien <= io_wdata[0];
      ctrl_q.thr <= thr_sanitize(io_wdata[15:8]);
    end
  end

  // Sticky overflow: set by a byte offered while full, cleared by EOI bit0.
  // A new overflow in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ovf_q <= 1'b0;
    else if (dev_valid && fifo_full)    ovf_q <= 1'b1;
    else if (wr_eoi && io_wdata[0])     ovf_q <= 1'b0;
  end

  // Interrupt lifecycle FSM with registered irr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (intr_trigger) begin
            state_q <= PEND;
            irr_q   <= 1'b1;
          end
        end
        PEND: begin
          if (intr_ack) begin
            state_q <= SERVICE;
            irr_q   <= 1'b0;
          end else if (!ctrl_q.ien) begin
            state_q <= IDLE;
            irr_q   <= 1'b0;
          end
        end
        SERVICE: begin
          irr_q <= 1'b0;
          if (wr_eoi) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign io_rdata = io_rdata_q;
  assign irr      = irr_q;

endmodule
